// File: rtl/grant_arbiter_fsm.sv
// rtl/grant_arbiter_fsm.sv - round-robin request/grant/revoke arbiter for one shared resource
// Optional ack watchdog: define GRANT_ARB_ACK_WATCHDOG_EN to enable it.
module grant_arbiter_fsm #(
  parameter int N_CHANNELS  = 4,
  parameter int MAX_HOLD    = 16,
  parameter int ACK_TIMEOUT = 8,
  parameter int IDX_W       = $clog2(N_CHANNELS)
) (
  input  logic                  i_ck,
  input  logic                  i_srst,
  input  logic [N_CHANNELS-1:0] i_req,
  input  logic [N_CHANNELS-1:0] i_done,
  input  logic [N_CHANNELS-1:0] i_revokeAck,
  output logic [N_CHANNELS-1:0] o_grant,
  output logic [N_CHANNELS-1:0] o_revoke,
  output logic [IDX_W-1:0]      o_grantIdx,
  output logic [1:0]            o_state,
  output logic                  o_timeout,
  output logic                  o_ackErr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_GRANT  = 2'd2,
    ST_REVOKE = 2'd3
  } state_t;

  // Hold counter is sized to reach MAX_HOLD; a disabled limit still needs one bit.
  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
  localparam logic [N_CHANNELS-1:0] ONE_HOT0 = N_CHANNELS'(1);
  localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(N_CHANNELS - 1);

  state_t                  state;
  logic [IDX_W-1:0]        rr_ptr;
  logic [HOLD_W-1:0]       hold_cnt;

  logic [2*N_CHANNELS-1:0] req_dbl;
  logic [N_CHANNELS-1:0]   req_rot;
  logic                    win_found;
  int                      win_off;
  int                      win_sum;
  logic [IDX_W-1:0]        win_idx;

  logic                    grantee_done;
  logic                    grantee_gone;
  logic                    grantee_ack;
  logic                    hold_limit;

`ifdef GRANT_ARB_ACK_WATCHDOG_EN
  localparam int ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'((ACK_TIMEOUT > 0) ? (ACK_TIMEOUT - 1) : 0);
  logic [ACK_W-1:0]        ack_cnt;
  logic                    ack_err_q;
`endif

  // Rotate requests so the channel after the pointer sits at bit 0, then take the lowest set bit.
  always_comb begin
    req_dbl   = {i_req, i_req};
    req_rot   = N_CHANNELS'(req_dbl >> (int'(rr_ptr) + 1));
    win_found = 1'b0;
    win_off   = 0;
    for (int j = N_CHANNELS - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        win_found = 1'b1;
        win_off   = j;
      end
    end
    win_sum = int'(rr_ptr) + 1 + win_off;
    if (win_sum >= N_CHANNELS) begin
      win_sum = win_sum - N_CHANNELS;
    end
    win_idx = IDX_W'(win_sum);
  end

  // Per-grantee qualifiers; inputs from other channels never reach the FSM.
  always_comb begin
    grantee_done = i_done[o_grantIdx];
    grantee_gone = ~i_req[o_grantIdx];
    grantee_ack  = i_revokeAck[o_grantIdx];
    hold_limit   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  end

  // Arbiter FSM with all outputs registered alongside the state.
  always_ff @(posedge i_ck) begin
    if (i_srst) begin
      state      <= ST_IDLE;
      rr_ptr     <= PTR_RESET;
      hold_cnt   <= '0;
      o_grantIdx <= '0;
      o_grant    <= '0;
      o_revoke   <= '0;
      o_timeout  <= 1'b0;
`ifdef GRANT_ARB_ACK_WATCHDOG_EN
      ack_cnt    <= '0;
      ack_err_q  <= 1'b0;
`endif
    end else begin
      o_timeout <= 1'b0;
`ifdef GRANT_ARB_ACK_WATCHDOG_EN
      ack_err_q <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (|i_req) begin
            state <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (win_found) begin
            state      <= ST_GRANT;
            o_grantIdx <= win_idx;
            rr_ptr     <= win_idx;
            hold_cnt   <= '0;
            o_grant    <= ONE_HOT0 << win_idx;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_GRANT: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (grantee_done || grantee_gone || hold_limit) begin
            state     <= ST_REVOKE;
            o_grant   <= '0;
            o_revoke  <= ONE_HOT0 << o_grantIdx;
            // A normal completion in the limit cycle is not a timeout.
            o_timeout <= ~(grantee_done || grantee_gone);
`ifdef GRANT_ARB_ACK_WATCHDOG_EN
            ack_cnt   <= '0;
`endif
          end
        end

        ST_REVOKE: begin
          if (grantee_ack) begin
            state    <= ST_IDLE;
            o_revoke <= '0;
          end
`ifdef GRANT_ARB_ACK_WATCHDOG_EN
          else if (ack_cnt == ACK_LAST) begin
            state     <= ST_IDLE;
            o_revoke  <= '0;
            ack_err_q <= 1'b1;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
`endif
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_state = state;

`ifdef GRANT_ARB_ACK_WATCHDOG_EN
  assign o_ackErr = ack_err_q;
`else
  // Without the watchdog the ack timeout has no effect and the error flag folds to 0.
  localparam logic ACK_ERR_TIE = (ACK_TIMEOUT < 0);
  assign o_ackErr = ACK_ERR_TIE;
`endif

endmodule

// File: tb/tb_grant_arbiter_fsm.sv
// tb/tb_grant_arbiter_fsm.sv - directed bench with a behavioural reference model
module tb_grant_arbiter_fsm;
  localparam int N  = 4;
  localparam int MH = 16;
  localparam int AT = 8;

  logic       clk = 1'b0;
  logic       srst;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] ack;
  logic [3:0] grant;
  logic [3:0] revoke;
  logic [1:0] gidx;
  logic [1:0] state;
  logic       timeout;
  logic       ack_err;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  grant_arbiter_fsm #(
    .N_CHANNELS(N), .MAX_HOLD(MH), .ACK_TIMEOUT(AT), .IDX_W(2)
  ) dut (
    .i_ck(clk), .i_srst(srst), .i_req(req), .i_done(done), .i_revokeAck(ack),
    .o_grant(grant), .o_revoke(revoke), .o_grantIdx(gidx), .o_state(state),
    .o_timeout(timeout), .o_ackErr(ack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0..3, pointer/grantee as integers, grant length counted in cycles.
  int m_phase = 0, m_ptr = N - 1, m_idx = 0, m_held = 0, m_wait = 0;
  bit m_to = 0, m_err = 0;

  function automatic int pick(input int ptr, input logic [3:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    m_to  = 0;
    m_err = 0;
    if (srst) begin
      m_phase = 0; m_ptr = N - 1; m_idx = 0; m_held = 0; m_wait = 0;
    end else begin
      case (m_phase)
        0: if (req != 0) m_phase = 1;
        1: begin
          w = pick(m_ptr, req);
          if (w >= 0) begin
            m_phase = 2; m_idx = w; m_ptr = w; m_held = 0;
          end else m_phase = 0;
        end
        2: begin
          m_held++;
          if (done[m_idx] || !req[m_idx]) begin
            m_phase = 3; m_wait = 0;
          end else if (MH != 0 && m_held == MH) begin
            m_phase = 3; m_wait = 0; m_to = 1;
          end
        end
        default: begin
          if (ack[m_idx]) m_phase = 0;
`ifdef GRANT_ARB_ACK_WATCHDOG_EN
          else begin
            m_wait++;
            if (m_wait == AT) begin
              m_phase = 0; m_err = 1;
            end
          end
`endif
        end
      endcase
    end
  end

  // Every cycle after reset: compare all outputs against the model.
  always @(negedge clk) begin
    if (checking) begin
      check("state", int'(state), m_phase);
      check("grant", int'(grant), (m_phase == 2) ? (1 << m_idx) : 0);
      check("revoke", int'(revoke), (m_phase == 3) ? (1 << m_idx) : 0);
      check("grant_idx", int'(gidx), m_idx);
      check("timeout", int'(timeout), int'(m_to));
      check("ack_err", int'(ack_err), int'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_grant(output int g);
    int n = 0;
    while (grant == 0 && n < 40) begin
      tick();
      n++;
    end
    if (grant == 0) check("wait_grant_bound", n, -1);
    g = int'(gidx);
  endtask

  task automatic release_grant(input int g);
    done = '0; done[g] = 1'b1;
    tick();
    done = '0;
    ack = '0; ack[g] = 1'b1;
    tick();
    ack = '0;
  endtask

  int exp_rr[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int g, n;

  initial begin
    srst = 1'b1; req = 4'b1111; done = '0; ack = '0;
    tick();
    checking = 1'b1;
    tick();
    check("rst_state", int'(state), 0);
    check("rst_grant", int'(grant), 0);
    check("rst_outs", int'({revoke, gidx, timeout, ack_err}), 0);
    srst = 1'b0;
    tick();
    tick();
    check("first_grant_lat", int'(grant), 4'b0001);

    // Round-robin with all requesters active
    for (int i = 0; i < 8; i++) begin
      wait_grant(g);
      check("rr_order", g, exp_rr[i]);
      if (i < 7) release_grant(g);
    end

    // Wrap and skip: ch3 releases, only ch1/ch2 request
    done = 4'b1000;
    tick();
    done = '0;
    req = 4'b0110;
    ack = 4'b1000;
    tick();
    ack = '0;
    wait_grant(g);
    check("skip_idx", g, 1);
    check("skip_grant", int'(grant), 4'b0010);
    req = '0;
    release_grant(g);

    // Forced revoke after MAX_HOLD cycles
    req = 4'b0001;
    wait_grant(g);
    n = 0;
    while (grant != 0 && n < 40) begin
      n++;
      tick();
    end
    check("hold_len", n, 16);
    check("timeout_pulse", int'(timeout), 1);
    check("timeout_revoke", int'(revoke), 4'b0001);
    req = '0;
    tick();
    check("timeout_one_cycle", int'(timeout), 0);
    ack = 4'b0001;
    tick();
    ack = '0;

    // Done in the limit cycle is a normal completion
    req = 4'b0001;
    wait_grant(g);
    repeat (15) tick();
    done = 4'b0001;
    tick();
    done = '0;
    check("late_done_no_timeout", int'(timeout), 0);
    check("late_done_revoke", int'(revoke), 4'b0001);
    req = '0;
    ack = 4'b0001;
    tick();
    ack = '0;
    tick();

    // Withdraw in REQUESTING
    req = 4'b0100;
    tick();
    check("wd_req_state", int'(state), 1);
    req = '0;
    tick();
    check("wd_back_idle", int'(state), 0);
    tick();
    check("wd_no_grant", int'(grant), 0);

    // Withdraw in GRANT, foreign ack, reset mid-REVOKE
    req = 4'b0100;
    wait_grant(g);
    req = '0;
    tick();
    check("wd_grant_revoke", int'(state), 3);
    ack = 4'b1011;
    tick();
    tick();
    check("foreign_ack_stay", int'(state), 3);
    ack = '0;
    srst = 1'b1;
    tick();
    check("rst_revoke_state", int'(state), 0);
    check("rst_revoke_outs", int'({grant, revoke, gidx}), 0);
    srst = 1'b0;
    tick();

`ifdef GRANT_ARB_ACK_WATCHDOG_EN
    req = 4'b0100;
    wait_grant(g);
    req = '0;
    tick();
    n = 0;
    while (state == 2'd3 && n < 40) begin
      n++;
      tick();
    end
    check("wdog_len", n, 8);
    check("wdog_err", int'(ack_err), 1);
    tick();
    check("wdog_err_one_cycle", int'(ack_err), 0);
`endif

    tick();
    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/grant_arbiter_fsm.md
# grant_arbiter_fsm

- Multi-channel successor to the single-requester request/grant state machine.
- Arbitrates `N_CHANNELS` requesters with round-robin fairness.
- Walks the shared resource through IDLE, REQUESTING, GRANT and REVOKE.
- Enforces a maximum grant hold time and a revoke/acknowledge handshake.
- Sits between requesting agents and a single shared resource; its one-hot grant and revoke vectors drive the agents directly.

## Interface
- `N_CHANNELS`, default 4: number of requesters; legal range 2..32.
- `MAX_HOLD`, default 16: maximum GRANT cycles before a forced revoke; 0 disables the limit.
- `ACK_TIMEOUT`, default 8: REVOKE cycles before the watchdog fires; used only with `GRANT_ARB_ACK_WATCHDOG_EN`.
- `IDX_W`, default `$clog2(N_CHANNELS)`: width of the grant index.
- `i_ck`  input  1  clock; all logic is on the rising edge.
- `i_srst`  input  1  reset, synchronous and active-high.
- `i_req`  input  N_CHANNELS  request level per channel.
- `i_done`  input  N_CHANNELS  grantee finished; sampled only for the current grantee.
- `i_revokeAck`  input  N_CHANNELS  grantee released the resource; sampled only for the current grantee.
- `o_grant`  output  N_CHANNELS  one-hot grant; high only in GRANT.
- `o_revoke`  output  N_CHANNELS  one-hot revoke request; high only in REVOKE.
- `o_grantIdx`  output  IDX_W  index of the current/last grantee.
- `o_state`  output  2  current state: IDLE=0, REQUESTING=1, GRANT=2, REVOKE=3.
- `o_timeout`  output  1  one-cycle pulse when a grant is forcibly revoked by `MAX_HOLD`.
- `o_ackErr`  output  1  one-cycle watchdog pulse; tied 0 when the macro is absent.

## Operation
- **Reset:**
  - State goes to IDLE; every output reads 0.
  - The round-robin pointer is set to N_CHANNELS-1, so channel 0 has first priority.
  - The hold and ack counters clear.
  - Reset mid-GRANT or mid-REVOKE drops the grant/revoke on the next edge, with no handshake.
- **IDLE:** go to REQUESTING when `|i_req`.
- **REQUESTING:**
  - The winner is the first set `i_req` bit searching upward from pointer+1, wrapping modulo N_CHANNELS.
  - If there is a winner: go to GRANT, latch `o_grantIdx`, set pointer = winner, clear the hold counter.
  - If all requests have been withdrawn: return to IDLE, pointer unchanged.
- **GRANT:**
  - `o_grant[idx]`=1 and the hold counter increments each cycle.
  - Go to REVOKE on any of:
    - `i_done[idx]`;
    - `i_req[idx]` deasserted;
    - `MAX_HOLD`≠0 and hold counter == `MAX_HOLD`-1.
  - Done/withdraw in the same cycle as the limit counts as a normal completion: no `o_timeout`.
- **REVOKE:**
  - `o_revoke[idx]`=1 and `o_grant`=0.
  - Go to IDLE on `i_revokeAck[idx]`.
  - Ack from a non-grantee is ignored.
- **Ignored inputs:** `i_done`/`i_revokeAck` on non-grantee channels, and in IDLE/REQUESTING.
- **Hold counter:** width `$clog2(MAX_HOLD+1)`; it never wraps because the limit always leaves GRANT first.

## Timing
- All outputs are registered (Moore); each is a function of the state register and index only.
- Request latency: request seen in cycle 0 (IDLE) → REQUESTING in cycle 1 → `o_grant` high in cycle 2.
- Forced grant length is exactly `MAX_HOLD` cycles.
- `o_timeout` is high in the first REVOKE cycle only.
- Release latency: `i_done` seen in GRANT cycle n → `o_revoke` in n+1 → ack seen in cycle m → IDLE in m+1.
- Back-to-back grants: the minimum turnaround is 3 cycles (REVOKE→IDLE→REQUESTING→GRANT).
- There is no combinational path from input to output.

## Configuration
- **With `GRANT_ARB_ACK_WATCHDOG_EN` defined:**
  - An ack counter runs in REVOKE.
  - If no `i_revokeAck[idx]` arrives by count `ACK_TIMEOUT`-1, the FSM forces IDLE.
  - `o_ackErr` pulses for one cycle, coincident with the IDLE entry.
  - An ack in the same cycle as expiry wins, and there is no error.
- **Without it:**
  - REVOKE waits indefinitely.
  - The ack counter is absent and `o_ackErr` is constant 0.

## Test plan
- **Reset:** assert `i_srst` with `i_req`=4'b1111 → all outputs 0, `o_state`=0; after release, channel 0 is granted in cycle 2.
- **Round-robin:** hold `i_req`=4'b1111, pulse `i_done`/`i_revokeAck` per grant → grant order 0,1,2,3,0.
- **Wrap and skip:** grant to ch3, then `i_req`=4'b0110 → next grant goes to ch1, `o_grantIdx`=1.
- **Timeout:** `MAX_HOLD`=16, no `i_done` → `o_grant` high exactly 16 cycles, then `o_timeout`=1 for one cycle with `o_revoke` high.
  - `i_done` on cycle 15 of the grant → no `o_timeout`.
- **Withdraw:**
  - Drop `i_req` in REQUESTING → return to IDLE, no grant.
  - Drop the grantee's `i_req` in GRANT → REVOKE next cycle.
  - A non-grantee ack in REVOKE → FSM stays in REVOKE.
- **Reset and watchdog:**
  - `i_srst` mid-REVOKE → IDLE next cycle with all outputs 0.
  - With the macro defined and `ACK_TIMEOUT`=8, no ack → `o_ackErr` pulse with IDLE entry after 8 REVOKE cycles.
